// File: rtl/sparhixcel_mem_loader.sv
// sparhixcel_mem_loader: turns a header-framed valid/ready word stream into
// registered write strobes on the feature, weight and ROM-signal memories.
//
// Handshake: a word transfers on a rising edge where s_valid_i && s_ready_o.
// s_ready_o depends only on lock_i and rst_i, never on s_valid_i. The source
// may raise or drop s_valid_i freely. A cycle with no transfer leaves the FSM,
// the address and the count untouched.
module sparhixcel_mem_loader #(
  parameter int DATA_WIDTH    = 72,
  parameter int ROM_SIG_WIDTH = 63,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     lock_i,
  output logic [DATA_WIDTH-1:0]    mem_data_o,
  output logic [ADDR_WIDTH-1:0]    wr_addrs_mem_o,
  output logic                     wr_mem_ld_o,
  output logic [DATA_WIDTH-1:0]    mem2_data_o,
  output logic [ADDR_WIDTH-1:0]    wr_addrs_mem2_o,
  output logic                     wr_mem2_ld_o,
  output logic [ROM_SIG_WIDTH-1:0] rom_signals_data_o,
  output logic [ADDR_WIDTH-1:0]    wr_addrs_rom_signal_o,
  output logic                     wr_rom_signals_ld_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // Burst length field is fixed at 10 bits (1..1024 words).
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {HDR = 2'd0, DATA = 2'd1, DISCARD = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;   // words remaining minus one

  logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic                     mem_ld_q, mem_ld_d;
  logic [DATA_WIDTH-1:0]    mem2_data_q, mem2_data_d;
  logic [ADDR_WIDTH-1:0]    mem2_addr_q, mem2_addr_d;
  logic                     mem2_ld_q, mem2_ld_d;
  logic [ROM_SIG_WIDTH-1:0] rom_data_q, rom_data_d;
  logic [ADDR_WIDTH-1:0]    rom_addr_q, rom_addr_d;
  logic                     rom_ld_q, rom_ld_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     accept;

  assign s_ready_o = !lock_i && !rst_i;
  assign accept    = s_valid_i && s_ready_o;

  // Next-state, counters and registered write-port values.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mem_data_d  = mem_data_q;
    mem_addr_d  = mem_addr_q;
    mem_ld_d    = 1'b0;
    mem2_data_d = mem2_data_q;
    mem2_addr_d = mem2_addr_q;
    mem2_ld_d   = 1'b0;
    rom_data_d  = rom_data_q;
    rom_addr_d  = rom_addr_q;
    rom_ld_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      HDR: begin
        if (accept) begin
          tgt_d  = s_data_i[1:0];
          addr_d = s_data_i[2 +: ADDR_WIDTH];
          cnt_d  = s_data_i[12 +: CNT_W];
          if (s_data_i[1:0] == 2'd3) begin
            state_d = DISCARD;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          case (tgt_q)
            2'd0: begin
              mem_ld_d   = 1'b1;
              mem_addr_d = addr_q;
              mem_data_d = s_data_i;
            end
            2'd1: begin
              mem2_ld_d   = 1'b1;
              mem2_addr_d = addr_q;
              mem2_data_d = s_data_i;
            end
            default: begin
              rom_ld_d   = 1'b1;
              rom_addr_d = addr_q;
              rom_data_d = s_data_i[ROM_SIG_WIDTH-1:0];
            end
          endcase
          addr_d = addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_d = HDR;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept) begin
          if (cnt_q == '0) begin
            state_d = HDR;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = HDR;
    endcase

    // Busy covers the cycle after the header through the cycle after the
    // last word, so it is set if either the current or next state is in a burst.
    busy_d = (state_q != HDR) || (state_d != HDR);
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HDR;
      tgt_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_ld_q    <= 1'b0;
      mem2_data_q <= '0;
      mem2_addr_q <= '0;
      mem2_ld_q   <= 1'b0;
      rom_data_q  <= '0;
      rom_addr_q  <= '0;
      rom_ld_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mem_data_q  <= mem_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_ld_q    <= mem_ld_d;
      mem2_data_q <= mem2_data_d;
      mem2_addr_q <= mem2_addr_d;
      mem2_ld_q   <= mem2_ld_d;
      rom_data_q  <= rom_data_d;
      rom_addr_q  <= rom_addr_d;
      rom_ld_q    <= rom_ld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_data_o            = mem_data_q;
  assign wr_addrs_mem_o        = mem_addr_q;
  assign wr_mem_ld_o           = mem_ld_q;
  assign mem2_data_o           = mem2_data_q;
  assign wr_addrs_mem2_o       = mem2_addr_q;
  assign wr_mem2_ld_o          = mem2_ld_q;
  assign rom_signals_data_o    = rom_data_q;
  assign wr_addrs_rom_signal_o = rom_addr_q;
  assign wr_rom_signals_ld_o   = rom_ld_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign err_o                 = err_q;

endmodule

// File: tb/tb_sparhixcel_mem_loader.sv
// Testbench for sparhixcel_mem_loader: directed test-plan scenarios followed
// by random bursts, every cycle compared against a burst-level reference model.
module tb_sparhixcel_mem_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic [71:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        lock    = 1'b0;

  logic        s_ready_o;
  logic [71:0] mem_data_o, mem2_data_o;
  logic [9:0]  wr_addrs_mem_o, wr_addrs_mem2_o, wr_addrs_rom_signal_o;
  logic        wr_mem_ld_o, wr_mem2_ld_o, wr_rom_signals_ld_o;
  logic [62:0] rom_signals_data_o;
  logic        busy_o, done_o, err_o;

  sparhixcel_mem_loader dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .s_data_i              (s_data),
    .s_valid_i             (s_valid),
    .s_ready_o             (s_ready_o),
    .lock_i                (lock),
    .mem_data_o            (mem_data_o),
    .wr_addrs_mem_o        (wr_addrs_mem_o),
    .wr_mem_ld_o           (wr_mem_ld_o),
    .mem2_data_o           (mem2_data_o),
    .wr_addrs_mem2_o       (wr_addrs_mem2_o),
    .wr_mem2_ld_o          (wr_mem2_ld_o),
    .rom_signals_data_o    (rom_signals_data_o),
    .wr_addrs_rom_signal_o (wr_addrs_rom_signal_o),
    .wr_rom_signals_ld_o   (wr_rom_signals_ld_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .err_o                 (err_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Burst-level view: a burst is (target, start, length) and word k of the
  // burst lands at (start + k) mod 1024.
  int m_phase = 0;   // 0 = expecting header, 1 = writing, 2 = discarding
  int m_tgt   = 0;
  int m_start = 0;
  int m_len   = 0;
  int m_idx   = 0;

  logic [71:0] e_mem_data = '0, e_mem2_data = '0;
  logic [62:0] e_rom_data = '0;
  logic [9:0]  e_mem_addr = '0, e_mem2_addr = '0, e_rom_addr = '0;
  logic        e_mem_ld = 0, e_mem2_ld = 0, e_rom_ld = 0;
  logic        e_busy = 0, e_done = 0, e_err = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic v, input logic [71:0] d, input logic lk, input logic r);
    bit was_busy;
    int a;
    if (r) begin
      m_phase = 0;
      e_mem_data = '0; e_mem2_data = '0; e_rom_data = '0;
      e_mem_addr = '0; e_mem2_addr = '0; e_rom_addr = '0;
      e_mem_ld = 0; e_mem2_ld = 0; e_rom_ld = 0;
      e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      was_busy = (m_phase != 0);
      e_mem_ld = 0; e_mem2_ld = 0; e_rom_ld = 0; e_done = 0; e_err = 0;
      if (v && !lk) begin
        if (m_phase == 0) begin
          m_tgt   = int'(d[1:0]);
          m_start = int'(d[11:2]);
          m_len   = int'(d[21:12]) + 1;
          m_idx   = 0;
          m_phase = (m_tgt == 3) ? 2 : 1;
          e_err   = (m_tgt == 3);
        end else begin
          a = (m_start + m_idx) % 1024;
          if (m_phase == 1) begin
            if (m_tgt == 0) begin
              e_mem_ld = 1; e_mem_addr = a[9:0]; e_mem_data = d;
            end else if (m_tgt == 1) begin
              e_mem2_ld = 1; e_mem2_addr = a[9:0]; e_mem2_data = d;
            end else begin
              e_rom_ld = 1; e_rom_addr = a[9:0]; e_rom_data = d[62:0];
            end
          end
          m_idx++;
          if (m_idx == m_len) begin
            e_done  = (m_phase == 1);
            m_phase = 0;
          end
        end
      end
      e_busy = was_busy || (m_phase != 0);
    end
  endtask

  task automatic check_outputs();
    check("mem_ld",    {71'd0, wr_mem_ld_o},           {71'd0, e_mem_ld});
    check("mem_addr",  {62'd0, wr_addrs_mem_o},        {62'd0, e_mem_addr});
    check("mem_data",  mem_data_o,                     e_mem_data);
    check("mem2_ld",   {71'd0, wr_mem2_ld_o},          {71'd0, e_mem2_ld});
    check("mem2_addr", {62'd0, wr_addrs_mem2_o},       {62'd0, e_mem2_addr});
    check("mem2_data", mem2_data_o,                    e_mem2_data);
    check("rom_ld",    {71'd0, wr_rom_signals_ld_o},   {71'd0, e_rom_ld});
    check("rom_addr",  {62'd0, wr_addrs_rom_signal_o}, {62'd0, e_rom_addr});
    check("rom_data",  {9'd0, rom_signals_data_o},     {9'd0, e_rom_data});
    check("busy",      {71'd0, busy_o},                {71'd0, e_busy});
    check("done",      {71'd0, done_o},                {71'd0, e_done});
    check("err",       {71'd0, err_o},                 {71'd0, e_err});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [71:0] d, input logic lk, input logic r);
    s_valid = v; s_data = d; lock = lk; rst = r;
    #1;
    check("s_ready", {71'd0, s_ready_o}, {71'd0, (!lk && !r)});
    @(posedge clk);
    model_update(v, d, lk, r);
    #1;
    check_outputs();
  endtask

  function automatic logic [71:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  function automatic logic [71:0] hdr(input int tgt, input int start, input int lenm1);
    logic [71:0] h;
    h = rnd_word();          // bits above 21 are don't-care
    h[1:0]   = tgt[1:0];
    h[11:2]  = start[9:0];
    h[21:12] = lenm1[9:0];
    return h;
  endfunction

  // Sends one word, optionally preceded by random idle and locked cycles.
  task automatic xfer(input logic [71:0] d, input bit rnd);
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) step(1'b1, rnd_word(), 1'b1, 1'b0);
        else                           step(1'b0, rnd_word(), 1'b0, 1'b0);
      end
    end
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [71:0] w;
    int lenm1;

    // Reset
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("reset_busy", {71'd0, busy_o}, 72'd0);

    // Feature burst: start 5, three words back-to-back
    step(1'b0, '0, 1'b0, 1'b0);
    xfer(hdr(0, 5, 2), 0);
    xfer(72'hA, 0);
    check("feat_first_addr", {62'd0, wr_addrs_mem_o}, 72'd5);
    xfer(72'hB, 0);
    xfer(72'hC, 0);
    check("feat_last_addr", {62'd0, wr_addrs_mem_o}, 72'd7);
    check("feat_last_data", mem_data_o, 72'hC);
    check("feat_done", {71'd0, done_o}, 72'd1);

    // Weight burst with valid bubbles 1,0,1,1,0,1
    xfer(hdr(1, 0, 3), 0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b0, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b0, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    check("wgt_last_addr", {62'd0, wr_addrs_mem2_o}, 72'd3);

    // ROM burst wrapping past 1023, bit 70 set in data
    xfer(hdr(2, 1022, 3), 0);
    for (int i = 0; i < 4; i++) begin
      w = rnd_word();
      w[70] = 1'b1;
      xfer(w, 0);
    end
    check("rom_wrap_addr", {62'd0, wr_addrs_rom_signal_o}, 72'd1);

    // Invalid target then a normal one-word feature burst
    xfer(hdr(3, 9, 1), 0);
    check("inv_err", {71'd0, err_o}, 72'd1);
    xfer(rnd_word(), 0);
    xfer(rnd_word(), 0);
    xfer(hdr(0, 100, 0), 0);
    xfer(72'h123, 0);
    check("after_inv_addr", {62'd0, wr_addrs_mem_o}, 72'd100);

    // Lock stall after 2nd of 4 words
    xfer(hdr(0, 200, 3), 0);
    xfer(rnd_word(), 0);
    xfer(rnd_word(), 0);
    repeat (3) step(1'b1, rnd_word(), 1'b1, 1'b0);
    xfer(rnd_word(), 0);
    xfer(rnd_word(), 0);
    check("lock_last_addr", {62'd0, wr_addrs_mem_o}, 72'd203);

    // Reset mid-burst, next accepted word is a header
    xfer(hdr(1, 50, 2), 0);
    xfer(rnd_word(), 0);
    step(1'b1, rnd_word(), 1'b0, 1'b1);
    check("rst_mid_addr", {62'd0, wr_addrs_mem2_o}, 72'd0);
    xfer(hdr(2, 7, 0), 0);
    check("rst_hdr_no_strobe", {71'd0, wr_rom_signals_ld_o}, 72'd0);
    xfer(rnd_word(), 0);
    check("rst_next_addr", {62'd0, wr_addrs_rom_signal_o}, 72'd7);

    // Random bursts with gaps and locks
    for (int b = 0; b < 30; b++) begin
      lenm1 = $urandom_range(0, 7);
      xfer(hdr($urandom_range(0, 3), $urandom_range(0, 1023), lenm1), 1);
      for (int k = 0; k <= lenm1; k++) xfer(rnd_word(), 1);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
